mux16_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one Mux16 16-bit datapath between two packet sources. It owns the Mux16 select line and registers the selected word into a single-stage output buffer with valid/ready flow control. The grant is held for a whole packet, up to a burst limit. It sits between two 16-bit producers and one downstream consumer, with the Mux16 instance as its datapath.

---
 rtl/mux16_arbiter.sv | 138 +++++++++++++
 tb/tb_mux16_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux16_arbiter.sv
// Two-requester round-robin arbiter in front of a Mux16 datapath.
// The grant is held for one packet, or until the burst limit is reached.
// The selected word is registered into a one-deep output buffer that uses
// valid/ready handshaking.
module mux16_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in0_data,
  input  logic        in0_valid,
  input  logic        in0_last,
  output logic        in0_ready,
  input  logic [15:0] in1_data,
  input  logic        in1_valid,
  input  logic        in1_last,
  output logic        in1_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        sel,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;
  localparam logic [3:0] CNT_END = 4'(MAX_BURST - 1);

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;

  logic [15:0] mux_y;
  logic        drain_ok, xfer, cur_last, rel_grant;

  // The registered select drives the shared datapath, so it always matches the lock state.
  mux16 u_mux (
    .sel (sel_q),
    .a   (in0_data),
    .b   (in1_data),
    .y   (mux_y)
  );

  // The buffer can take a new word when it is empty or is being drained this cycle.
  always_comb begin
    drain_ok  = !out_valid_q || out_ready;
    in0_ready = (state_q == LOCK0) && drain_ok;
    in1_ready = (state_q == LOCK1) && drain_ok;
    xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    cur_last  = sel_q ? in1_last : in0_last;
    // A grant ends on the packet's last beat, or is forced to end at the burst limit.
    rel_grant = xfer && (cur_last || (cnt_q == CNT_END));
  end

  // Arbitration, beat counting and output buffer next state.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (xfer) begin
      out_data_d  = mux_y;
      out_valid_d = 1'b1;
      out_last_d  = rel_grant;
      cnt_d       = cnt_q + 4'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) state_d = prio_q ? LOCK1 : LOCK0;
        else if (in0_valid)         state_d = LOCK0;
        else if (in1_valid)         state_d = LOCK1;
      end
      LOCK0, LOCK1: begin
        if (rel_grant) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          prio_d  = (state_q == LOCK0);
        end
      end
      default: state_d = IDLE;
    endcase

    // The select follows the lock state and keeps its last value while idle.
    if (state_d == LOCK0)      sel_d = 1'b0;
    else if (state_d == LOCK1) sel_d = 1'b1;
    else                       sel_d = sel_q;
  end

  // State registers; a synchronous reset also drops any buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= 4'd0;
      sel_q       <= 1'b0;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// 16-bit two-input word multiplexer (0 = a, 1 = b).
module mux16 (
  input  logic        sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = sel ? b : a;
endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter. Each source drives its words from a queue.
// A behavioural model checks every DUT output on every cycle. The log of
// words the consumer accepts is also compared against the expected packet order.
module tb_mux16_arbiter;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in0_data, in1_data, out_data;
  logic        in0_valid, in0_last, in0_ready;
  logic        in1_valid, in1_last, in1_ready;
  logic        out_valid, out_last, out_ready, sel, busy;

  int total = 0;
  int bad   = 0;
  int p_v0, p_v1, p_rdy;

  // Queued words are {last, data}.
  logic [16:0] qs0[$], qs1[$], olog[$];

  // Reference state: grant is -1 when idle, otherwise the index of the requester holding it.
  int          m_gnt, m_prio, m_cnt;
  bit          m_sel, m_oval, m_olast;
  logic [15:0] m_odata;

  mux16_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(string tag, logic [16:0] exp[$]);
    chk({tag, "_len"}, 32'(olog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < olog.size(); i++)
      chk(tag, 32'(olog[i]), 32'(exp[i]));
  endtask

  // One clock cycle: drive the sources, check the DUT against the model, then advance the model.
  task automatic cycle();
    logic [16:0] w0, w1;
    bit r0, r1, xf, e;
    int g;
    if (qs0.size() > 0) w0 = qs0[0]; else w0 = {1'b0, 16'($urandom)};
    if (qs1.size() > 0) w1 = qs1[0]; else w1 = {1'b0, 16'($urandom)};
    in0_valid = (qs0.size() > 0) && ($urandom_range(99) < 32'(p_v0));
    in1_valid = (qs1.size() > 0) && ($urandom_range(99) < 32'(p_v1));
    in0_data = w0[15:0]; in0_last = w0[16];
    in1_data = w1[15:0]; in1_last = w1[16];
    out_ready = ($urandom_range(99) < 32'(p_rdy));
    #2;
    r0 = (m_gnt == 0) && (!m_oval || out_ready);
    r1 = (m_gnt == 1) && (!m_oval || out_ready);
    chk("in0_ready", 32'(in0_ready), 32'(r0));
    chk("in1_ready", 32'(in1_ready), 32'(r1));
    chk("out_valid", 32'(out_valid), 32'(m_oval));
    chk("out_data",  32'(out_data),  32'(m_odata));
    chk("out_last",  32'(out_last),  32'(m_olast));
    chk("sel",       32'(sel),       32'(m_sel));
    chk("busy",      32'(busy),      32'(m_gnt >= 0));
    if (!rst) begin
      if (out_valid && out_ready) olog.push_back({out_last, out_data});
      if (in0_valid && r0) void'(qs0.pop_front());
      if (in1_valid && r1) void'(qs1.pop_front());
    end
    if (rst) begin
      m_gnt = -1; m_prio = 0; m_cnt = 0; m_sel = 0;
      m_oval = 0; m_odata = 16'h0; m_olast = 0;
    end else begin
      g  = m_gnt;
      xf = (g == 0 && in0_valid && r0) || (g == 1 && in1_valid && r1);
      if (xf) begin
        m_odata = (g == 1) ? in1_data : in0_data;
        m_oval  = 1;
        m_cnt++;
        e = ((g == 1) ? in1_last : in0_last) || (m_cnt == MB);
        m_olast = e;
        if (e) begin m_cnt = 0; m_prio = 1 - g; m_gnt = -1; end
      end else if (m_oval && out_ready) begin
        m_oval = 0;
      end
      if (g < 0) begin
        if (in0_valid && in1_valid) m_gnt = m_prio;
        else if (in0_valid)         m_gnt = 0;
        else if (in1_valid)         m_gnt = 1;
        if (m_gnt >= 0) m_sel = (m_gnt == 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    qs0.delete(); qs1.delete(); olog.delete();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [16:0] exp[$];
    logic [15:0] hold;
    int pushed;
    rst = 1'b1; in0_valid = 0; in1_valid = 0; in0_last = 0; in1_last = 0;
    in0_data = 0; in1_data = 0; out_ready = 0;
    p_v0 = 100; p_v1 = 100; p_rdy = 100;
    m_gnt = -1; m_prio = 0; m_cnt = 0; m_sel = 0; m_oval = 0; m_odata = 0; m_olast = 0;
    @(posedge clk); #1;

    // Reset state, checked inside the reset cycle, then a single one-word packet from in0.
    do_reset();
    qs0.push_back(17'h1A5A5);
    cycle();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_sel", 32'(sel), 32'd0);
    chk("t1_rdy", 32'(in0_ready), 32'd1);
    cycle();
    chk("t1_data", 32'(out_data), 32'h0000A5A5);
    chk("t1_val", 32'(out_valid), 32'd1);
    chk("t1_last", 32'(out_last), 32'd1);
    run(2);
    // prio must now favour in1.
    qs0.push_back(17'h10BBB); qs1.push_back(17'h11BBB);
    run(8);
    exp = '{17'h1A5A5, 17'h11BBB, 17'h10BBB};
    chk_log("t1_order", exp);

    // Simultaneous two-word packets after reset.
    do_reset();
    qs0.push_back(17'h00001); qs0.push_back(17'h10002);
    qs1.push_back(17'h01001); qs1.push_back(17'h11002);
    run(10);
    exp = '{17'h00001, 17'h10002, 17'h01001, 17'h11002};
    chk_log("simul", exp);

    // Fairness with one-word packets on both sides.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      qs0.push_back(17'h10A00 | 17'(k));
      qs1.push_back(17'h11A00 | 17'(k));
    end
    run(20);
    exp.delete();
    for (int k = 1; k <= 4; k++) begin
      exp.push_back(17'h10A00 | 17'(k));
      exp.push_back(17'h11A00 | 17'(k));
    end
    chk_log("fair", exp);

    // Burst limit: 6 in1 words, only the 6th marked last, while in0 waits.
    do_reset();
    for (int k = 1; k <= 6; k++) qs1.push_back({(k == 6), 16'h2000 | 16'(k)});
    cycle();
    qs0.push_back(17'h10001);
    run(20);
    exp = '{17'h02001, 17'h02002, 17'h02003, 17'h12004, 17'h10001, 17'h02005, 17'h12006};
    chk_log("burst", exp);

    // Backpressure mid-packet.
    do_reset();
    qs0.push_back(17'h03001); qs0.push_back(17'h03002); qs0.push_back(17'h13003);
    run(3);
    hold = out_data;
    p_rdy = 0;
    repeat (3) begin
      cycle();
      chk("bp_hold", 32'(out_data), 32'(hold));
      chk("bp_rdy0", 32'(in0_ready), 32'd0);
    end
    p_rdy = 100;
    run(5);
    exp = '{17'h03001, 17'h03002, 17'h13003};
    chk_log("bp", exp);

    // Reset while LOCK1 holds a buffered word.
    do_reset();
    qs1.push_back(17'h04001); qs1.push_back(17'h04002); qs1.push_back(17'h14003);
    run(2);
    p_rdy = 0;
    cycle();
    chk("mr_pre_busy", 32'(busy), 32'd1);
    chk("mr_pre_sel", 32'(sel), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mr_val", 32'(out_valid), 32'd0);
    chk("mr_sel", 32'(sel), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    qs0.delete(); qs1.delete(); olog.delete();
    p_rdy = 100;
    qs0.push_back(17'h15001); qs1.push_back(17'h15002);
    run(8);
    exp = '{17'h15001, 17'h15002};
    chk_log("mr_prio", exp);

    // Random traffic: random packets, valid gaps and backpressure.
    do_reset();
    pushed = 0;
    for (int p = 0; p < 25; p++) begin
      int len0, len1;
      len0 = int'($urandom_range(7, 1));
      len1 = int'($urandom_range(7, 1));
      for (int k = 0; k < len0; k++) qs0.push_back({(k == len0 - 1), 16'($urandom)});
      for (int k = 0; k < len1; k++) qs1.push_back({(k == len1 - 1), 16'($urandom)});
      pushed += len0 + len1;
    end
    p_v0 = 75; p_v1 = 75; p_rdy = 70;
    run(700);
    p_v0 = 100; p_v1 = 100; p_rdy = 100;
    run(300);
    chk("rnd_count", 32'(olog.size()), 32'(pushed));
    chk("rnd_q0_empty", 32'(qs0.size()), 32'd0);
    chk("rnd_q1_empty", 32'(qs1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
